fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared types and sizing for the instruction fetch path.
//
// Contents:
//   ADDR_W, WORD_W   word address width and instruction word width
//   FETCH_DEPTH      instruction buffer depth (4 with FETCH_PREFETCH_EN, else 1)
//   FETCH_CNT_W      width of a buffer occupancy count (0..FETCH_DEPTH)
//   instruction_t    buffered instruction: fetched word plus its address
//   fetch_state_e    fetch FSM states
//
// Configuration macro: FETCH_PREFETCH_EN
//   defined   -> 4-entry buffer, fetching runs ahead of the consumer
//   undefined -> single-entry buffer, one instruction in hand at a time
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 32;

`ifdef FETCH_PREFETCH_EN
  localparam int FETCH_DEPTH = 4;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction memory read bus between the fetch unit and memory.
//
// Signals:
//   mem_rd     read request, held until mem_ready
//   mem_addr   word address, stable while mem_rd=1
//   mem_data   read data, valid when mem_ready=1
//   mem_ready  read completes this cycle
//
// Modports:
//   master  fetch unit side (drives mem_rd/mem_addr)
//   slave   memory side (drives mem_data/mem_ready)
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data,
    output mem_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small circular instruction buffer.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push      write din at the tail (ignored when full unless popping too)
//   pop       drop the head entry (ignored when empty)
//   clear     empty the buffer; wins over push/pop
//   din       entry to write
//   head      entry at the head (meaningful only when empty=0)
//   full      occupancy == DEPTH
//   empty     occupancy == 0
//   count     current occupancy
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  instruction_t     din,
  output instruction_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  // Pointers need at least one bit even for a single-entry buffer; storage is
  // rounded up to a power of two so any pointer value indexes a real slot.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << PTR_W;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  instruction_t     mem [SLOTS];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full buffer may still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
      else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage needs no reset: nothing is read from a slot before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch engine with a small instruction buffer.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        fetch_unit_if.master: mem_rd/mem_addr out, mem_data/mem_ready in
//   ir         instruction word at buffer head (0 when buffer empty)
//   ir_pc      address ir was fetched from (0 when buffer empty)
//   ir_valid   ir/ir_pc hold a valid instruction
//   ld_ir      consume the head instruction (ignored when ir_valid=0)
//   ld_pc      redirect fetching to pc_in and flush the buffer
//   pc_in      redirect target
//   stop       no new requests; an in-flight request still completes
//
// Configuration macro: FETCH_PREFETCH_EN (buffer depth 4 when defined, else 1),
// resolved through cpu_pkg::FETCH_DEPTH.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      bus,
  output logic [WORD_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ld_ir,
  input  logic              ld_pc,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              stop
);

  fetch_state_e           state;
  logic [ADDR_W-1:0]      fpc;
  logic [ADDR_W-1:0]      fpc_inc;
  instruction_t           head;
  instruction_t           din;
  logic                   full;
  logic                   empty;
  logic [FETCH_CNT_W-1:0] count;
  logic [FETCH_CNT_W:0]   occ_after;
  logic                   push;
  logic                   pop;
  logic                   can_issue;
  logic                   room_after;

  // A redirect flushes the buffer, so it overrides both consume and push.
  assign pop  = ld_ir && !empty && !ld_pc;
  assign push = (state == REQ) && bus.mem_ready && !ld_pc;
  assign din  = '{word: bus.mem_data, pc: fpc};

  assign fpc_inc = fpc + ADDR_W'(1);

  // Occupancy once this cycle's push and any pop have both landed.
  assign occ_after  = {1'b0, count} + (FETCH_CNT_W + 1)'(1)
                    - {{FETCH_CNT_W{1'b0}}, pop};
  assign room_after = (occ_after < (FETCH_CNT_W + 1)'(FETCH_DEPTH));

  // Starting from IDLE, a full buffer may still issue if the head leaves now.
  assign can_issue = !full || pop;

  fetch_fifo #(
    .DEPTH (FETCH_DEPTH),
    .CNT_W (FETCH_CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (ld_pc),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign ir_valid = !empty;
  assign ir       = empty ? '0 : head.word;
  assign ir_pc    = empty ? '0 : head.pc;

  // Fetch FSM. mem_rd/mem_addr are registered and only change at request
  // boundaries, so the address is stable for the whole request. DRAIN waits
  // out a request made obsolete by a redirect and throws its data away.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fpc          <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_pc) begin
            fpc <= pc_in;
          end else if (can_issue && !stop) begin
            state        <= REQ;
            bus.mem_rd   <= 1'b1;
            bus.mem_addr <= fpc;
          end
        end
        REQ: begin
          if (ld_pc) begin
            fpc <= pc_in;
            if (bus.mem_ready) begin
              state      <= IDLE;
              bus.mem_rd <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (bus.mem_ready) begin
            fpc <= fpc_inc;
            if (room_after && !stop) begin
              bus.mem_addr <= fpc_inc;
            end else begin
              state      <= IDLE;
              bus.mem_rd <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (ld_pc) fpc <= pc_in;
          if (bus.mem_ready) begin
            state      <= IDLE;
            bus.mem_rd <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          bus.mem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule
